// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Optional build macro: BIN2BCD_LEADING_BLANK_EN. When it is defined, leading zero digits
// above the most significant nonzero digit are published as 4'hF so that the downstream
// 7-segment decoder blanks them. Digit 0 is never blanked.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int          CW = $clog2(WIDTH + 1);
    localparam int unsigned ND = DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic                  ovf_scratch;
    logic [CW-1:0]         count;
    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   published;

    // Add-3 correction of every scratch digit that is 5 or more, ahead of the shift
    always_comb begin
        adjusted = scratch;
        for (int unsigned i = 0; i < ND; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN2BCD_LEADING_BLANK_EN
    logic seen_nonzero;

    // Replace zero digits above the most significant nonzero digit with the blank code
    always_comb begin
        published    = scratch;
        seen_nonzero = 1'b0;
        for (int unsigned k = 0; k + 1 < ND; k++) begin
            if (!seen_nonzero && (scratch[4*(ND-1-k) +: 4] == 4'd0)) begin
                published[4*(ND-1-k) +: 4] = 4'hF;
            end else begin
                seen_nonzero = 1'b1;
            end
        end
    end
`else
    // Plain BCD with leading zeros
    always_comb begin
        published = scratch;
    end
`endif

    // Conversion FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            scratch     <= '0;
            ovf_scratch <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg       <= bin;
                        scratch     <= '0;
                        ovf_scratch <= 1'b0;
                        count       <= '0;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch     <= {adjusted[4*DIGITS-2:0], shreg[WIDTH-1]};
                    shreg       <= shreg << 1;
                    ovf_scratch <= ovf_scratch | adjusted[4*DIGITS-1];
                    count       <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd      <= published;
                    overflow <= ovf_scratch;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
